// File: rtl/hpm_sample_ctrl.sv
// Periodic sampler and port arbiter for the HPM counter bank (mhpmcounter3..8).
// Define HPM_SAMPLE_TIMESTAMP_EN to add sample_ts_o, a per-sweep cycle timestamp.
module hpm_sample_ctrl #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned PeriodWidth = 16,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   csr_req_i,
  input  logic [11:0]            csr_addr_i,
  input  logic                   csr_we_i,
  input  logic [DataWidth-1:0]   csr_wdata_i,
  output logic                   csr_gnt_o,
  output logic [DataWidth-1:0]   csr_rdata_o,
  output logic [11:0]            pc_addr_o,
  output logic                   pc_we_o,
  output logic [DataWidth-1:0]   pc_wdata_o,
  input  logic [DataWidth-1:0]   pc_rdata_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [2:0]             sample_idx_o,
  output logic [DataWidth-1:0]   sample_data_o,
`ifdef HPM_SAMPLE_TIMESTAMP_EN
  output logic [63:0]            sample_ts_o,
`endif
  output logic                   overrun_o,
  input  logic                   overrun_clr_i
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned PW = AW + 1;
  localparam logic [11:0] BaseAddr = 12'hB03;
  localparam logic [2:0]  LastK    = 3'(NumCounters - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CSR, OWN_SMP} owner_e;

  state_e state_reg, state_next;
  owner_e owner_reg, owner_next;
  logic [2:0] k_reg, k_next;
  logic [2:0] smp_idx_reg;
  logic [PeriodWidth-1:0] timer_reg;
  logic [DataWidth-1:0] csr_hold_reg;
  logic overrun_reg;
  logic timer_run, tick, sweep_active, issue;

  // Tick timer: loads on first enabled cycle, fires and reloads when it reaches 1
  assign timer_run = enable_i && (period_i != '0);
  assign tick      = timer_run && (timer_reg == PeriodWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_reg <= '0;
    end else if (!timer_run) begin
      timer_reg <= '0;
    end else if ((timer_reg == '0) || (timer_reg == PeriodWidth'(1))) begin
      timer_reg <= period_i;
    end else begin
      timer_reg <= timer_reg - PeriodWidth'(1);
    end
  end

  // Sample FIFO with extra-MSB pointers
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] fill;
  logic [PW:0]   occupancy;
  logic          fifo_empty, fifo_full, slots_ok, push, pop;
  logic [2:0]           mem_idx  [FifoDepth];
  logic [DataWidth-1:0] mem_data [FifoDepth];

  assign fill       = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A read in flight already owns a slot, so it counts against free space
  assign occupancy  = {1'b0, fill} + {{PW{1'b0}}, (owner_reg == OWN_SMP)};
  assign slots_ok   = (occupancy < (PW+1)'(FifoDepth));
  assign push       = (owner_reg == OWN_SMP) && !fifo_full;
  assign pop        = !fifo_empty && sample_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_idx[i]  <= '0;
        mem_data[i] <= '0;
      end
    end else if (push) begin
      mem_idx[wr_ptr_reg[AW-1:0]]  <= smp_idx_reg;
      mem_data[wr_ptr_reg[AW-1:0]] <= pc_rdata_i;
    end
  end

  assign sample_valid_o = !fifo_empty;
  assign sample_idx_o   = mem_idx[rd_ptr_reg[AW-1:0]];
  assign sample_data_o  = mem_data[rd_ptr_reg[AW-1:0]];

`ifdef HPM_SAMPLE_TIMESTAMP_EN
  logic [63:0] cycle_reg, ts_reg;
  logic [63:0] mem_ts [FifoDepth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_reg <= '0;
      ts_reg    <= '0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;
      if ((state_reg == ST_IDLE) && tick) ts_reg <= cycle_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) mem_ts[i] <= '0;
    end else if (push) begin
      mem_ts[wr_ptr_reg[AW-1:0]] <= ts_reg;
    end
  end

  assign sample_ts_o = mem_ts[rd_ptr_reg[AW-1:0]];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // The tick cycle itself may issue k=0, so the first sample is visible at tick+2
  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    issue        = 1'b0;
    sweep_active = 1'b0;
    unique case (state_reg)
      ST_IDLE:  sweep_active = tick;
      ST_SWEEP: sweep_active = 1'b1;
      ST_DRAIN: if (owner_reg == OWN_SMP) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (sweep_active) begin
      if (state_reg == ST_IDLE) state_next = ST_SWEEP;
      if (!csr_req_i && slots_ok) begin
        issue = 1'b1;
        if (k_reg == LastK) begin
          k_next     = '0;
          state_next = ST_DRAIN;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end
    end
  end

  // Port mux: CSR always wins, sampler only reads
  always_comb begin
    pc_addr_o  = '0;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    owner_next = OWN_NONE;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
      owner_next = csr_we_i ? OWN_NONE : OWN_CSR;
    end else if (issue) begin
      pc_addr_o  = BaseAddr + 12'(k_reg);
      owner_next = OWN_SMP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_reg    <= OWN_NONE;
      smp_idx_reg  <= '0;
      csr_hold_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      if (issue) smp_idx_reg <= k_reg;
      if (owner_reg == OWN_CSR) csr_hold_reg <= pc_rdata_i;
      if (tick && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign csr_gnt_o   = csr_req_i;
  assign csr_rdata_o = (owner_reg == OWN_CSR) ? pc_rdata_i : csr_hold_reg;
  assign overrun_o   = overrun_reg;

endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Directed testbench for hpm_sample_ctrl with a registered-read counter bank model.
module tb_hpm_sample_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] period_i = '0;
  logic        csr_req_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic        csr_we_i = 1'b0;
  logic [63:0] csr_wdata_i = '0;
  logic        csr_gnt_o;
  logic [63:0] csr_rdata_o;
  logic [11:0] pc_addr_o;
  logic        pc_we_o;
  logic [63:0] pc_wdata_o;
  logic [63:0] pc_rdata_i;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b0;
  logic [2:0]  sample_idx_o;
  logic [63:0] sample_data_o;
  logic        overrun_o;
  logic        overrun_clr_i = 1'b0;
`ifdef HPM_SAMPLE_TIMESTAMP_EN
  logic [63:0] sample_ts_o;
`endif

  int cmp_cnt = 0;
  int fail_cnt = 0;

  always #5 clk_i = ~clk_i;

  hpm_sample_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .period_i(period_i),
    .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
    .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o), .csr_rdata_o(csr_rdata_o),
    .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o),
    .pc_rdata_i(pc_rdata_i), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .sample_idx_o(sample_idx_o),
    .sample_data_o(sample_data_o),
`ifdef HPM_SAMPLE_TIMESTAMP_EN
    .sample_ts_o(sample_ts_o),
`endif
    .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
  );

  // Counter bank: one port, data for cycle N address appears in N+1
  logic [63:0] bank [6] = '{64'hC0DE_0003_0000_1003, 64'hC0DE_0004_0000_2004,
                            64'hC0DE_0005_0000_3005, 64'hC0DE_0006_0000_4006,
                            64'hC0DE_0007_0000_5007, 64'hC0DE_0008_0000_6008};
  logic [63:0] exp_val [6] = '{64'hC0DE_0003_0000_1003, 64'hC0DE_0004_0000_2004,
                               64'hC0DE_0005_0000_3005, 64'hC0DE_0006_0000_4006,
                               64'hC0DE_0007_0000_5007, 64'hC0DE_0008_0000_6008};
  logic [11:0] bank_off;
  assign bank_off = pc_addr_o - 12'hB03;

  always @(posedge clk_i) begin
    if (pc_we_o && bank_off < 12'd6) bank[bank_off[2:0]] <= pc_wdata_o;
    pc_rdata_i <= (bank_off < 12'd6) ? bank[bank_off[2:0]] : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    enable_i = 1'b0; period_i = '0; csr_req_i = 1'b0; csr_addr_i = '0;
    csr_we_i = 1'b0; csr_wdata_i = '0; sample_ready_i = 1'b0; overrun_clr_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    cmp_cnt++; if (sample_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid: got %0b want 0", sample_valid_o); end
    cmp_cnt++; if (overrun_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_overrun: got %0b want 0", overrun_o); end
    cmp_cnt++; if (csr_rdata_o !== 64'd0) begin fail_cnt++; $display("FAIL rst_csr_rdata: got %0h want 0", csr_rdata_o); end
    cmp_cnt++; if (pc_addr_o !== 12'd0 || pc_we_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_pc: got addr %0h we %0b want 0/0", pc_addr_o, pc_we_o); end
    cmp_cnt++; if (sample_idx_o !== 3'd0 || sample_data_o !== 64'd0) begin fail_cnt++; $display("FAIL rst_head: got idx %0d data %0h want 0/0", sample_idx_o, sample_data_o); end
    step();
    rst_ni = 1'b1;
    step();
    cmp_cnt++; if (sample_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL post_rst_valid: got %0b want 0", sample_valid_o); end
  endtask

  task automatic test_periodic();
    do_reset();
    period_i = 16'd100; enable_i = 1'b1; sample_ready_i = 1'b1;
    repeat (99) step();
    cmp_cnt++; if (pc_addr_o !== 12'd0) begin fail_cnt++; $display("FAIL per_pre_tick: got addr %0h want 0", pc_addr_o); end
    step();
    cmp_cnt++; if (pc_addr_o !== 12'hB03 || pc_we_o !== 1'b0) begin fail_cnt++; $display("FAIL per_tick_issue: got addr %0h we %0b want b03/0", pc_addr_o, pc_we_o); end
    step();
    cmp_cnt++; if (sample_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL per_tick1_valid: got %0b want 0", sample_valid_o); end
    step();
    for (int i = 0; i < 6; i++) begin
      cmp_cnt++; if (sample_valid_o !== 1'b1 || sample_idx_o !== 3'(i)) begin fail_cnt++; $display("FAIL per_idx%0d: got valid %0b idx %0d want 1/%0d", i, sample_valid_o, sample_idx_o, i); end
      cmp_cnt++; if (sample_data_o !== exp_val[i]) begin fail_cnt++; $display("FAIL per_data%0d: got %0h want %0h", i, sample_data_o, exp_val[i]); end
      step();
    end
    cmp_cnt++; if (sample_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL per_after: got valid %0b want 0", sample_valid_o); end
    repeat (94) step();
    cmp_cnt++; if (sample_valid_o !== 1'b1 || sample_idx_o !== 3'd0) begin fail_cnt++; $display("FAIL per_second_sweep: got valid %0b idx %0d want 1/0", sample_valid_o, sample_idx_o); end
  endtask

  task automatic test_csr_stall();
    int got;
    logic [63:0] wval;
    do_reset();
    period_i = 16'd100; enable_i = 1'b1; sample_ready_i = 1'b1;
    repeat (101) step();
    csr_req_i = 1'b1; csr_addr_i = 12'hB05; csr_we_i = 1'b0;
    #1;
    cmp_cnt++; if (pc_addr_o !== 12'hB05 || csr_gnt_o !== 1'b1) begin fail_cnt++; $display("FAIL csr_mux: got addr %0h gnt %0b want b05/1", pc_addr_o, csr_gnt_o); end
    got = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 0) begin
        cmp_cnt++; if (csr_rdata_o !== exp_val[2]) begin fail_cnt++; $display("FAIL csr_rdata: got %0h want %0h", csr_rdata_o, exp_val[2]); end
      end
      if (c == 1) begin
        cmp_cnt++; if (pc_addr_o !== 12'hB05) begin fail_cnt++; $display("FAIL csr_hold_port: got addr %0h want b05", pc_addr_o); end
      end
      if (c == 2) begin
        csr_req_i = 1'b0;
        #1;
        cmp_cnt++; if (pc_addr_o !== 12'hB04) begin fail_cnt++; $display("FAIL csr_resume_k1: got addr %0h want b04", pc_addr_o); end
      end
      if (sample_valid_o === 1'b1) begin
        cmp_cnt++;
        if (got >= 6) begin
          fail_cnt++; $display("FAIL csr_extra_sample: got idx %0d want none", sample_idx_o);
        end else if (sample_idx_o !== 3'(got) || sample_data_o !== exp_val[got]) begin
          fail_cnt++; $display("FAIL csr_sample%0d: got idx %0d data %0h want %0d/%0h", got, sample_idx_o, sample_data_o, got, exp_val[got]);
        end
        got++;
      end
    end
    cmp_cnt++; if (got != 6) begin fail_cnt++; $display("FAIL csr_sample_count: got %0d want 6", got); end
    cmp_cnt++; if (csr_rdata_o !== exp_val[2]) begin fail_cnt++; $display("FAIL csr_rdata_hold: got %0h want %0h", csr_rdata_o, exp_val[2]); end
    wval = 64'h1234_5678_9ABC_DEF0;
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'hB07; csr_wdata_i = wval;
    #1;
    cmp_cnt++; if (pc_we_o !== 1'b1 || pc_wdata_o !== wval) begin fail_cnt++; $display("FAIL csr_write_port: got we %0b data %0h want 1/%0h", pc_we_o, pc_wdata_o, wval); end
    step();
    csr_we_i = 1'b0;
    step();
    csr_req_i = 1'b0;
    exp_val[4] = wval;
    cmp_cnt++; if (csr_rdata_o !== wval) begin fail_cnt++; $display("FAIL csr_readback: got %0h want %0h", csr_rdata_o, wval); end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    period_i = 16'd100; enable_i = 1'b1; sample_ready_i = 1'b0;
    repeat (100) step();
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++; if (pc_addr_o !== 12'hB03 + 12'(i)) begin fail_cnt++; $display("FAIL bp_issue%0d: got addr %0h want %0h", i, pc_addr_o, 12'hB03 + 12'(i)); end
      step();
    end
    cmp_cnt++; if (pc_addr_o !== 12'd0) begin fail_cnt++; $display("FAIL bp_stall: got addr %0h want 0", pc_addr_o); end
    repeat (5) step();
    cmp_cnt++; if (sample_valid_o !== 1'b1 || sample_idx_o !== 3'd0 || pc_addr_o !== 12'd0) begin fail_cnt++; $display("FAIL bp_full_hold: got valid %0b idx %0d addr %0h want 1/0/0", sample_valid_o, sample_idx_o, pc_addr_o); end
    sample_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (sample_valid_o === 1'b1) begin
        cmp_cnt++;
        if (got >= 6) begin
          fail_cnt++; $display("FAIL bp_extra_sample: got idx %0d want none", sample_idx_o);
        end else if (sample_idx_o !== 3'(got) || sample_data_o !== exp_val[got]) begin
          fail_cnt++; $display("FAIL bp_sample%0d: got idx %0d data %0h want %0d/%0h", got, sample_idx_o, sample_data_o, got, exp_val[got]);
        end
        got++;
      end
      step();
    end
    cmp_cnt++; if (got != 6) begin fail_cnt++; $display("FAIL bp_sample_count: got %0d want 6", got); end
  endtask

  task automatic test_overrun();
    do_reset();
    period_i = 16'd3; enable_i = 1'b1; sample_ready_i = 1'b0;
    repeat (6) step();
    cmp_cnt++; if (overrun_o !== 1'b0) begin fail_cnt++; $display("FAIL ovr_first_tick: got %0b want 0", overrun_o); end
    step();
    cmp_cnt++; if (overrun_o !== 1'b1) begin fail_cnt++; $display("FAIL ovr_second_tick: got %0b want 1", overrun_o); end
    overrun_clr_i = 1'b1;
    step();
    cmp_cnt++; if (overrun_o !== 1'b0) begin fail_cnt++; $display("FAIL ovr_clear: got %0b want 0", overrun_o); end
    step();
    cmp_cnt++; if (overrun_o !== 1'b0) begin fail_cnt++; $display("FAIL ovr_cleared_hold: got %0b want 0", overrun_o); end
    step();
    overrun_clr_i = 1'b0;
    cmp_cnt++; if (overrun_o !== 1'b1) begin fail_cnt++; $display("FAIL ovr_set_wins: got %0b want 1", overrun_o); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    period_i = 16'd100; enable_i = 1'b1; sample_ready_i = 1'b1;
    repeat (103) step();
    cmp_cnt++; if (pc_addr_o !== 12'hB06 || sample_valid_o !== 1'b1) begin fail_cnt++; $display("FAIL mid_k3: got addr %0h valid %0b want b06/1", pc_addr_o, sample_valid_o); end
    rst_ni = 1'b0;
    #1;
    cmp_cnt++; if (sample_valid_o !== 1'b0 || pc_addr_o !== 12'd0 || overrun_o !== 1'b0) begin fail_cnt++; $display("FAIL mid_rst_out: got valid %0b addr %0h ovr %0b want 0/0/0", sample_valid_o, pc_addr_o, overrun_o); end
    cmp_cnt++; if (sample_idx_o !== 3'd0 || sample_data_o !== 64'd0) begin fail_cnt++; $display("FAIL mid_rst_head: got idx %0d data %0h want 0/0", sample_idx_o, sample_data_o); end
    step();
    rst_ni = 1'b1;
    step();
    cmp_cnt++; if (sample_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL mid_inflight_dropped: got valid %0b want 0", sample_valid_o); end
    repeat (99) step();
    cmp_cnt++; if (pc_addr_o !== 12'hB03) begin fail_cnt++; $display("FAIL mid_restart_k0: got addr %0h want b03", pc_addr_o); end
    step();
    step();
    cmp_cnt++; if (sample_valid_o !== 1'b1 || sample_idx_o !== 3'd0 || sample_data_o !== exp_val[0]) begin fail_cnt++; $display("FAIL mid_restart_sample: got valid %0b idx %0d data %0h want 1/0/%0h", sample_valid_o, sample_idx_o, sample_data_o, exp_val[0]); end
  endtask

`ifdef HPM_SAMPLE_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    period_i = 16'd1000; enable_i = 1'b1; sample_ready_i = 1'b1;
    repeat (1002) step();
    for (int i = 0; i < 6; i++) begin
      cmp_cnt++; if (sample_valid_o !== 1'b1 || sample_ts_o !== 64'd1000) begin fail_cnt++; $display("FAIL ts_sample%0d: got valid %0b ts %0d want 1/1000", i, sample_valid_o, sample_ts_o); end
      step();
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_periodic();
    test_csr_stall();
    test_backpressure();
    test_overrun();
    test_reset_mid_sweep();
`ifdef HPM_SAMPLE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
